rom_scramble_ctrl: RTL and testbench

Sequencer that walks a programmable address window of the `rom` block and bit-scrambles each word. It drives the ROM's `oe_i`/`cs_ni`/`address_i` pins, captures `data_o`, applies the fixed interleave permutation, and issues one write per word to a destination memory port. It sits between the lab's ROM and any writable RAM image, replacing testbench-driven hierarchical scramble/write-back with synthesizable hardware under a start/done handshake.

---
 rtl/rom_scramble_ctrl.sv | 142 ++++++++++++++
 tb/tb_rom_scramble_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_scramble_ctrl.sv
// rtl/rom_scramble_ctrl.sv - ROM window walker that bit-interleaves each word and writes it to a destination port
// rom_scramble_perm is the interleave helper; rom_scramble_ctrl is the sequencer top.

module rom_scramble_perm #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  // MSB-first output order is d[0], d[W-1], d[1], d[W-2], ... folding inward
  always_comb begin
    q = '0;
    for (int i = 0; i < Width / 2; i++) begin
      q[Width-1-2*i] = d[i];
      q[Width-2-2*i] = d[Width-1-i];
    end
  end

endmodule

module rom_scramble_ctrl #(
  parameter int Width = 8,
  parameter int Depth = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [Depth-1:0] src_start_i,
  input  logic [Depth-1:0] src_end_i,
  input  logic [Depth-1:0] dst_base_i,
  output logic             rom_oe_o,
  output logic             rom_cs_no,
  output logic [Depth-1:0] rom_addr_o,
  input  logic [Width-1:0] rom_data_i,
  output logic             wr_en_o,
  output logic [Depth-1:0] wr_addr_o,
  output logic [Width-1:0] wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RELEASE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [Depth-1:0] end_q;
  logic [Depth-1:0] dst_q;
  logic [Depth-1:0] idx_q;
  logic [Width-1:0] cap_q;
  logic [Width-1:0] cap_scr;
  logic             in_xfer;
  logic             abort_hit;
  logic             last_word;

  rom_scramble_perm #(.Width(Width)) u_perm (
    .d(cap_q),
    .q(cap_scr)
  );

  assign in_xfer   = (state_q == S_SELECT) || (state_q == S_RELEASE) || (state_q == S_WRITE);
  assign abort_hit = abort_i && in_xfer;
  assign last_word = (rom_addr_o == end_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_SELECT;
      S_SELECT:  state_d = abort_i ? S_IDLE : S_RELEASE;
      S_RELEASE: state_d = abort_i ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (abort_i)        state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
        else                state_d = S_SELECT;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean Moore signal
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rom_oe_o   <= 1'b0;
      rom_cs_no  <= 1'b1;
      rom_addr_o <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      aborted_o  <= 1'b0;
      end_q      <= '0;
      dst_q      <= '0;
      idx_q      <= '0;
      cap_q      <= '0;
    end else begin
      state_q   <= state_d;
      rom_oe_o  <= (state_d == S_SELECT);
      rom_cs_no <= (state_d != S_SELECT);
      wr_en_o   <= (state_d == S_WRITE);
      busy_o    <= (state_d == S_SELECT) || (state_d == S_RELEASE) || (state_d == S_WRITE);
      done_o    <= (state_d == S_DONE);
      aborted_o <= abort_hit;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rom_addr_o <= src_start_i;
            end_q      <= src_end_i;
            dst_q      <= dst_base_i;
            idx_q      <= '0;
          end
        end
        S_SELECT: cap_q <= rom_data_i;
        S_RELEASE: begin
          // An abort here leaves the write port holding its previous word
          if (!abort_i) begin
            wr_data_o <= cap_scr;
            wr_addr_o <= dst_q + idx_q;
          end
        end
        S_WRITE: begin
          if (!abort_i && !last_word) begin
            rom_addr_o <= rom_addr_o + Depth'(1);
            idx_q      <= idx_q + Depth'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scramble_ctrl.sv
// tb/tb_rom_scramble_ctrl.sv - directed/randomized self-checking bench for rom_scramble_ctrl
module tb_rom_scramble_ctrl;

  localparam int W = 8;
  localparam int D = 5;
  localparam int NW = 1 << D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [D-1:0] src_s = '0, src_e = '0, dst_b = '0;
  logic         rom_oe, rom_cs_n, wr_en, busy, done, aborted;
  logic [D-1:0] rom_addr, wr_addr;
  logic [W-1:0] rom_data, wr_data;
  logic [W-1:0] rom [NW];

  rom_scramble_ctrl #(.Width(W), .Depth(D)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .src_start_i(src_s),
    .src_end_i  (src_e),
    .dst_base_i (dst_b),
    .rom_oe_o   (rom_oe),
    .rom_cs_no  (rom_cs_n),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
    .aborted_o  (aborted)
  );

  assign rom_data = (!rom_cs_n && rom_oe) ? rom[rom_addr] : '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [D-1:0]   rq[$];
  logic [D+W-1:0] wq[$];
  int done_cnt = 0, abort_cnt = 0, first_wr_cyc = -1;

  always @(negedge clk) begin
    if (!rom_cs_n && rom_oe) rq.push_back(rom_addr);
    if (wr_en) begin
      if (wq.size() == 0) first_wr_cyc = cyc;
      wq.push_back({wr_addr, wr_data});
    end
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  int total = 0, passed = 0, failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference interleave: build the source-bit pick list, then shift bits in MSB first
  function automatic logic [W-1:0] scr_model(input logic [W-1:0] d);
    int order[$];
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 2; i++) begin
      order.push_back(i);
      order.push_back(W - 1 - i);
    end
    foreach (order[j]) r = {r[W-2:0], d[order[j]]};
    return r;
  endfunction

  task automatic check_writes(input string tag, input logic [D-1:0] s, input logic [D-1:0] b,
                              input int n);
    logic [D-1:0] ra, wa;
    check({tag, "/nwrites"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      ra = s + i[D-1:0];
      wa = b + i[D-1:0];
      check({tag, "/wr"}, wq[i], {wa, scr_model(rom[ra])});
    end
  endtask

  task automatic run_xfer(input string tag, input logic [D-1:0] s, input logic [D-1:0] e,
                          input logic [D-1:0] b, input bit poke);
    int n, k, waited, d0;
    logic [D-1:0] ra;
    n = ((int'(e) - int'(s) + NW) % NW) + 1;
    rq.delete();
    wq.delete();
    first_wr_cyc = -1;
    d0 = done_cnt;
    @(negedge clk);
    src_s = s; src_e = e; dst_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    src_s = D'($urandom); src_e = D'($urandom); dst_b = D'($urandom);
    check({tag, "/busy"}, busy, 1'b1);
    waited = 0;
    while (!done && waited < 200) begin
      @(negedge clk);
      waited++;
      start = poke && (waited == 4);
      if (start) begin src_s = ~s; src_e = ~e; dst_b = ~b; end
    end
    start = 1'b0;
    check({tag, "/done_latency"}, waited, 3 * n);
    check({tag, "/first_wr"}, first_wr_cyc - k, 2);
    check({tag, "/nreads"}, rq.size(), n);
    for (int i = 0; i < n && i < rq.size(); i++) begin
      ra = s + i[D-1:0];
      check({tag, "/rd_addr"}, rq[i], ra);
    end
    check_writes(tag, s, b, n);
    @(negedge clk);
    check({tag, "/idle_busy"}, busy, 1'b0);
    check({tag, "/done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    int a0, d0;
    for (int i = 0; i < NW; i++) rom[i] = W'($urandom);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst/cs_n", rom_cs_n, 1'b1);
    check("rst/oe", rom_oe, 1'b0);
    check("rst/flags", {wr_en, busy, done, aborted}, 4'b0);
    check("rst/addrs", {rom_addr, wr_addr, wr_data}, '0);
    rst = 1'b0;

    run_xfer("window", 5'h10, 5'h17, 5'h10, 1'b0);
    run_xfer("single", 5'h1C, 5'h1C, 5'h03, 1'b0);
    run_xfer("wrap", 5'h1E, 5'h01, 5'h1F, 1'b0);
    run_xfer("full", 5'h05, 5'h04, D'($urandom), 1'b0);
    for (int t = 0; t < 4; t++)
      run_xfer("random", D'($urandom), D'($urandom), D'($urandom), 1'b0);

    run_xfer("ignored_start", 5'h08, 5'h0D, 5'h15, 1'b1);
    rq.delete();
    repeat (6) @(negedge clk);
    check("ignored_start/no_second", rq.size(), 0);
    check("ignored_start/still_idle", busy, 1'b0);

    // abort while idle has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort/no_pulse", aborted, 1'b0);
    check("idle_abort/busy", busy, 1'b0);

    // abort during the third SELECT of window 0x04..0x0B
    rq.delete(); wq.delete();
    a0 = abort_cnt; d0 = done_cnt;
    @(negedge clk);
    src_s = 5'h04; src_e = 5'h0B; dst_b = 5'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort/in_select", {rom_cs_n, rom_oe, rom_addr}, {2'b01, 5'h06});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/pulse", aborted, 1'b1);
    check("abort/cs_n", rom_cs_n, 1'b1);
    check("abort/busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check_writes("abort", 5'h04, 5'h12, 2);
    check("abort/pulse_count", abort_cnt - a0, 1);
    check("abort/no_done", done_cnt - d0, 0);

    // reset held two cycles while in WRITE
    wq.delete();
    d0 = done_cnt;
    @(negedge clk);
    src_s = 5'h00; src_e = 5'h07; dst_b = 5'h09; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/in_write", wr_en, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst/cs_n", rom_cs_n, 1'b1);
    check("midrst/flags", {rom_oe, wr_en, busy, done, aborted}, 5'b0);
    check("midrst/addrs", {rom_addr, wr_addr, wr_data}, '0);
    repeat (30) @(negedge clk);
    check("midrst/no_done", done_cnt - d0, 0);
    check("midrst/one_write", wq.size(), 1);

    run_xfer("after_rst", D'($urandom), D'($urandom), D'($urandom), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
